// File: rtl/thermo_accum_ctrl_pkg.sv
// Shared widths and FSM state encoding for the thermometer accumulator.
package thermo_accum_ctrl_pkg;
    localparam int THERMO_W = 8;
    localparam int BIN_W    = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/thermo_accum_ctrl_t2b.sv
// Thermometer-to-binary converter; any code that is not a contiguous
// run of ones from bit 0 flags a bubble and converts to zero.
module thermo2bin
    import thermo_accum_ctrl_pkg::*;
(
    input  logic [THERMO_W-1:0] thermo,
    output logic [BIN_W-1:0]    count,
    output logic                bubble
);
    always_comb begin
        count  = '0;
        bubble = 1'b0;
        for (int unsigned i = 0; i < THERMO_W; i++) begin
            count = count + BIN_W'(thermo[i]);
        end
        // A valid code plus one carries out of every set bit, leaving no overlap.
        if ((thermo & (thermo + THERMO_W'(1))) != '0) begin
            bubble = 1'b1;
            count  = '0;
        end
    end
endmodule

// File: rtl/thermo_accum_ctrl.sv
// Windowed accumulator of thermometer samples with valid/ready output
// and sticky bubble/overrun flags.
module thermo_accum_ctrl
    import thermo_accum_ctrl_pkg::*;
#(
    parameter int OSF  = 8,
    parameter int SUMW = 4 + $clog2(OSF)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sample_valid,
    input  logic [THERMO_W-1:0] thermo_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SUMW-1:0]     out_sum,
    input  logic                clr_flags,
    output logic                bubble_err,
    output logic                overrun
);
    localparam int CNTW = $clog2(OSF);
    localparam logic [CNTW-1:0] LAST = CNTW'(OSF - 1);

    state_t          state;
    logic [SUMW-1:0] acc;
    logic [CNTW-1:0] cnt;
    logic [BIN_W-1:0] count;
    logic            bubble;
    logic            accept;
    logic            complete;
    logic            take;
    logic            load;
    logic [SUMW-1:0] sum_next;

    thermo2bin u_t2b (
        .thermo (thermo_in),
        .count  (count),
        .bubble (bubble)
    );

    assign accept   = (state == RUN) && en && sample_valid;
    assign complete = accept && (cnt == LAST);
    assign take     = out_valid && out_ready;
    // A completing window loads only if the output slot is free or draining now.
    assign load     = complete && (!out_valid || out_ready);
    assign sum_next = acc + SUMW'(count);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            bubble_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        state <= RUN;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state <= IDLE;
                        acc   <= '0;
                        cnt   <= '0;
                    end else if (accept) begin
                        if (complete) begin
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            acc <= sum_next;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (load) begin
                out_valid <= 1'b1;
                out_sum   <= sum_next;
            end else if (take) begin
                out_valid <= 1'b0;
            end

            // Set events are written last so they win over a same-cycle clear.
            if (clr_flags) begin
                bubble_err <= 1'b0;
                overrun    <= 1'b0;
            end
            if (accept && bubble) begin
                bubble_err <= 1'b1;
            end
            if (complete && !load) begin
                overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_thermo_accum_ctrl.sv
// Scoreboard bench: directed windows push expected sums, a negedge
// monitor pops and checks them on every output handshake.
module tb_thermo_accum_ctrl;
    localparam int OSF  = 8;
    localparam int SUMW = 4 + $clog2(OSF);

    logic            clk;
    logic            rst;
    logic            en;
    logic            sample_valid;
    logic [7:0]      thermo_in;
    logic            out_valid;
    logic            out_ready;
    logic [SUMW-1:0] out_sum;
    logic            clr_flags;
    logic            bubble_err;
    logic            overrun;

    int tests;
    int fails;
    int exp_q[$];

    thermo_accum_ctrl #(.OSF(OSF), .SUMW(SUMW)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .sample_valid (sample_valid),
        .thermo_in    (thermo_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sum      (out_sum),
        .clr_flags    (clr_flags),
        .bubble_err   (bubble_err),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic samples(input logic [7:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            thermo_in    = v;
            sample_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        sample_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_flags = 1'b1;
        cycles(1);
        clr_flags = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_out: got out_sum=%0d, expected no result at %0t", out_sum, $time);
            end else begin
                check("out_sum_scoreboard", int'(out_sum), exp_q.pop_front());
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        en = 1'b0;
        sample_valid = 1'b0;
        thermo_in = 8'h00;
        out_ready = 1'b1;
        clr_flags = 1'b0;
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_sum", int'(out_sum), 0);
        check("reset_bubble", int'(bubble_err), 0);
        check("reset_overrun", int'(overrun), 0);
        #11;
        rst = 1'b0;
        cycles(2);

        // Single window of 00001111, one-cycle latency, one-cycle valid
        en = 1'b1;
        cycles(1);
        exp_q.push_back(32);
        samples(8'h0F, 8);
        check("latency_valid", int'(out_valid), 1);
        check("latency_sum", int'(out_sum), 32);
        cycles(1);
        check("valid_clears", int'(out_valid), 0);

        // Back-to-back windows with no gap
        exp_q.push_back(64);
        exp_q.push_back(8);
        samples(8'hFF, 8);
        check("b2b_first_sum", int'(out_sum), 64);
        samples(8'h01, 8);
        check("b2b_second_valid", int'(out_valid), 1);
        check("b2b_second_sum", int'(out_sum), 8);
        check("b2b_overrun", int'(overrun), 0);
        cycles(1);

        // Stalled consumer across two windows: second result dropped
        out_ready = 1'b0;
        exp_q.push_back(16);
        samples(8'h03, 8);
        samples(8'h01, 8);
        check("stall_sum_kept", int'(out_sum), 16);
        check("stall_overrun", int'(overrun), 1);
        pulse_clr();
        check("overrun_cleared", int'(overrun), 0);
        out_ready = 1'b1;
        cycles(1);
        check("stall_drained", int'(out_valid), 0);

        // Window completing on the same edge as the handshake
        out_ready = 1'b0;
        exp_q.push_back(8);
        exp_q.push_back(16);
        samples(8'h01, 8);
        samples(8'h03, 7);
        out_ready = 1'b1;
        samples(8'h03, 1);
        check("same_edge_valid", int'(out_valid), 1);
        check("same_edge_sum", int'(out_sum), 16);
        check("same_edge_overrun", int'(overrun), 0);
        cycles(1);

        // Bubble code counts as zero and sets the sticky flag
        exp_q.push_back(7);
        samples(8'h01, 3);
        samples(8'h05, 1);
        samples(8'h01, 4);
        check("bubble_set", int'(bubble_err), 1);
        cycles(1);
        pulse_clr();
        check("bubble_cleared", int'(bubble_err), 0);

        // Set beats clear in the same cycle; window then aborted by en=0
        clr_flags = 1'b1;
        samples(8'h05, 1);
        clr_flags = 1'b0;
        check("bubble_priority", int'(bubble_err), 1);
        pulse_clr();
        samples(8'h01, 4);
        en = 1'b0;
        cycles(1);

        // IDLE ignores samples, including bubble codes
        samples(8'h05, 2);
        check("idle_no_bubble", int'(bubble_err), 0);
        check("idle_no_valid", int'(out_valid), 0);
        en = 1'b1;
        cycles(1);
        exp_q.push_back(8);
        samples(8'h01, 8);
        check("restart_sum", int'(out_sum), 8);
        cycles(2);

        // Asynchronous reset with a pending result and an open window
        out_ready = 1'b0;
        samples(8'h0F, 8);
        samples(8'h05, 1);
        samples(8'h01, 2);
        check("pre_rst_valid", int'(out_valid), 1);
        check("pre_rst_bubble", int'(bubble_err), 1);
        #2;
        en = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_async_valid", int'(out_valid), 0);
        check("rst_async_sum", int'(out_sum), 0);
        check("rst_async_bubble", int'(bubble_err), 0);
        check("rst_async_overrun", int'(overrun), 0);
        #3;
        rst = 1'b0;
        out_ready = 1'b1;
        cycles(1);
        samples(8'h01, 8);
        check("post_rst_waits_en", int'(out_valid), 0);
        en = 1'b1;
        cycles(1);
        exp_q.push_back(8);
        samples(8'h01, 8);
        check("post_rst_sum", int'(out_sum), 8);
        cycles(3);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
